// File: rtl/fire_nav_pkg.sv
// fire_nav_pkg: shared constants for the fire-fighting robot navigation block.
// State codes, H-bridge motor command patterns, obstacle sensor bit positions
// and the per-side dead-time helper.
package fire_nav_pkg;

    // State codes; the explicit values are what state_o exposes for debug.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_SEARCH     = 3'd1;
    localparam state_t ST_APPROACH   = 3'd2;
    localparam state_t ST_AVOID_REV  = 3'd3;
    localparam state_t ST_AVOID_TURN = 3'd4;
    localparam state_t ST_EXTINGUISH = 3'd5;
    localparam state_t ST_FAULT      = 3'd6;

    // Motor commands as {left_fwd, left_bwd, right_fwd, right_bwd}.
    typedef logic [3:0] motor_cmd_t;
    localparam motor_cmd_t CMD_STOP   = 4'b0000;
    localparam motor_cmd_t CMD_FWD    = 4'b1010;
    localparam motor_cmd_t CMD_REV    = 4'b0101;
    localparam motor_cmd_t CMD_SPIN_R = 4'b1001;
    localparam motor_cmd_t CMD_SPIN_L = 4'b0110;

    // Bit positions inside obs_n = {left, front, right}.
    localparam int OBS_RIGHT = 0;
    localparam int OBS_FRONT = 1;
    localparam int OBS_LEFT  = 2;

    // Next {fwd, bwd} for one side: a direct forward<->backward reversal is
    // replaced by one cycle of 00 so both bridge legs are never on together.
    function automatic logic [1:0] side_next(input logic [1:0] cur,
                                             input logic [1:0] req);
        if ((cur == 2'b10 && req == 2'b01) || (cur == 2'b01 && req == 2'b10))
            return 2'b00;
        return req;
    endfunction

endpackage

// File: rtl/fire_nav_fsm_sensor_debounce.sv
// sensor_debounce: two-flop synchroniser followed by a counting debouncer for
// one active-low sensor bit. The filtered output only moves after the
// synchronised bit has disagreed with it for DEB_CYCLES consecutive cycles,
// giving a raw-to-filtered latency of DEB_CYCLES+2 cycles.
module sensor_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic           sync1;
    logic           sync2;
    logic [CW-1:0]  cnt;

    // Bring the asynchronous sensor into the clk domain; idle level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1,
            // which is what builds the two-stage chain.
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreement cycles; flip the filtered bit on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (sync2 != filt) begin
            if (cnt == CW'(DEB_CYCLES - 1)) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/fire_nav_fsm.sv
// fire_nav_fsm: registered navigation and extinguish controller for the
// fire-fighting robot. Debounces the obstacle and flame sensors, runs the
// search / approach / avoid / extinguish state machine with a shared
// manoeuvre timer, and drives the H-bridge with one-cycle dead time.
// Build option: define FIRE_NAV_RETRY_LIMIT_EN to add the FAULT state that is
// entered after MAX_RETRY consecutive pump bursts.
module fire_nav_fsm
    import fire_nav_pkg::*;
#(
    parameter int N_FLAME     = 3,
    parameter int DEB_CYCLES  = 4,
    parameter int REV_CYCLES  = 1000,
    parameter int TURN_CYCLES = 500,
    parameter int PUMP_CYCLES = 2000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [2:0]         obs_n,
    input  logic [N_FLAME-1:0] flame_n,
    output logic               left_fwd,
    output logic               left_bwd,
    output logic               right_fwd,
    output logic               right_bwd,
    output logic               buzzer,
    output logic               pump,
    output logic [2:0]         state_o
);

    localparam int CENTRE  = N_FLAME / 2;
    // Sized for the fault threshold with headroom; saturates when unlimited.
    localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;

    logic [2:0]         obs_f;
    logic [N_FLAME-1:0] flame_f;

    for (genvar i = 0; i < 3; i++) begin : g_obs
        sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (obs_n[i]),
            .filt (obs_f[i])
        );
    end

    for (genvar i = 0; i < N_FLAME; i++) begin : g_flame
        sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (flame_n[i]),
            .filt (flame_f[i])
        );
    end

    // Active-high views of the filtered sensors.
    logic [N_FLAME-1:0] flame_act;
    logic flame_c, flame_l, flame_r, flame_any;
    logic obs_front, obs_right;
    logic obs_left_unused;

    assign flame_act       = ~flame_f;
    assign flame_c         = flame_act[CENTRE];
    assign flame_l         = |flame_act[N_FLAME-1:CENTRE+1];
    assign flame_r         = |flame_act[CENTRE-1:0];
    assign flame_any       = |flame_act;
    assign obs_front       = ~obs_f[OBS_FRONT];
    assign obs_right       = ~obs_f[OBS_RIGHT];
    assign obs_left_unused = obs_f[OBS_LEFT];

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   timer, nxt_timer;
    logic [RETRY_W-1:0] retry, nxt_retry, retry_up;
    logic               turn_left, nxt_turn_left;
    logic               fault_buzz, nxt_fault_buzz;
    logic               timer_zero;

    assign timer_zero = (timer == '0);
    assign retry_up   = (&retry) ? retry : retry + 1'b1;
    assign state_o    = state;

    // Next-state, timer, retry and turn-direction decisions.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned and infers a latch.
        nxt_state      = state;
        nxt_timer      = timer_zero ? '0 : timer - 1'b1;
        nxt_retry      = retry;
        nxt_turn_left  = turn_left;
        nxt_fault_buzz = fault_buzz;
        if (!enable) begin
            nxt_state      = ST_IDLE;
            nxt_timer      = '0;
            nxt_retry      = '0;
            nxt_fault_buzz = 1'b0;
        end else begin
            case (state)
                ST_IDLE: nxt_state = ST_SEARCH;
                ST_SEARCH: begin
                    if (flame_c) begin
                        nxt_state = ST_EXTINGUISH;
                        nxt_timer = CNT_W'(PUMP_CYCLES - 1);
                    end else if (flame_l || flame_r) begin
                        nxt_state = ST_APPROACH;
                    end else if (obs_front) begin
                        nxt_state = ST_AVOID_REV;
                        nxt_timer = CNT_W'(REV_CYCLES - 1);
                    end
                end
                ST_APPROACH: begin
                    if (flame_c) begin
                        nxt_state = ST_EXTINGUISH;
                        nxt_timer = CNT_W'(PUMP_CYCLES - 1);
                    end else if (!flame_any) begin
                        nxt_state = ST_SEARCH;
                    end
                end
                ST_AVOID_REV: begin
                    if (timer_zero) begin
                        nxt_state     = ST_AVOID_TURN;
                        nxt_timer     = CNT_W'(TURN_CYCLES - 1);
                        nxt_turn_left = obs_right;
                    end
                end
                ST_AVOID_TURN: begin
                    if (timer_zero) nxt_state = ST_SEARCH;
                end
                ST_EXTINGUISH: begin
                    if (timer_zero) begin
                        if (flame_any) begin
                            nxt_retry = retry_up;
                            nxt_timer = CNT_W'(PUMP_CYCLES - 1);
`ifdef FIRE_NAV_RETRY_LIMIT_EN
                            if (retry_up == RETRY_W'(MAX_RETRY)) begin
                                nxt_state      = ST_FAULT;
                                nxt_fault_buzz = 1'b0;
                            end
`endif
                        end else begin
                            nxt_state = ST_SEARCH;
                            nxt_retry = '0;
                        end
                    end
                end
`ifdef FIRE_NAV_RETRY_LIMIT_EN
                ST_FAULT: begin
                    if (timer_zero) begin
                        nxt_timer      = CNT_W'(PUMP_CYCLES - 1);
                        nxt_fault_buzz = ~fault_buzz;
                    end
                end
`endif
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            retry      <= '0;
            turn_left  <= 1'b0;
            fault_buzz <= 1'b0;
        end else begin
            state      <= nxt_state;
            timer      <= nxt_timer;
            retry      <= nxt_retry;
            turn_left  <= nxt_turn_left;
            fault_buzz <= nxt_fault_buzz;
        end
    end

    motor_cmd_t cmd_d;
    logic       pump_d, buzz_d;

    // Requested actuator values for the current state.
    always_comb begin
        cmd_d  = CMD_STOP;
        pump_d = 1'b0;
        buzz_d = 1'b0;
        case (state)
            ST_SEARCH:     cmd_d = CMD_SPIN_L;
            ST_APPROACH:   cmd_d = flame_l ? CMD_SPIN_L :
                                   (flame_r ? CMD_SPIN_R : CMD_STOP);
            ST_AVOID_REV:  cmd_d = CMD_REV;
            ST_AVOID_TURN: cmd_d = turn_left ? CMD_SPIN_L : CMD_SPIN_R;
            ST_EXTINGUISH: begin
                pump_d = 1'b1;
                buzz_d = 1'b1;
            end
`ifdef FIRE_NAV_RETRY_LIMIT_EN
            ST_FAULT:      buzz_d = fault_buzz;
`endif
            default:       cmd_d = CMD_STOP;
        endcase
    end

    // Registered outputs with per-side dead time; enable=0 clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {left_fwd, left_bwd}   <= 2'b00;
            {right_fwd, right_bwd} <= 2'b00;
            pump                   <= 1'b0;
            buzzer                 <= 1'b0;
        end else if (!enable) begin
            {left_fwd, left_bwd}   <= 2'b00;
            {right_fwd, right_bwd} <= 2'b00;
            pump                   <= 1'b0;
            buzzer                 <= 1'b0;
        end else begin
            {left_fwd, left_bwd}   <= side_next({left_fwd, left_bwd}, cmd_d[3:2]);
            {right_fwd, right_bwd} <= side_next({right_fwd, right_bwd}, cmd_d[1:0]);
            pump                   <= pump_d;
            buzzer                 <= buzz_d;
        end
    end

endmodule
